// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
package counter_pkg;

    // Direction encoding for the 'up' input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Minimum number of bits needed to hold the values 0..n-1.
    function automatic int min_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Up/down modulo-N counter with parallel load, terminal-count cascade
// output, wrap/load-error pulses and an optional one-shot (halt) mode.
module mod_n_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 12,
    parameter int ONE_SHOT = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err,
    output logic             halted
);

    // Reject parameter sets that cannot represent the full count range.
    generate
        if (MODULUS < 2 || WIDTH < min_width(MODULUS)) begin : g_bad_params
            $error("mod_n_counter: MODULUS must be >= 2 and fit in WIDTH bits");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic             HALT_EN  = (ONE_SHOT != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             halted_q, halted_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;

    logic             at_term;
    logic             load_ok;

    // Terminal value for the current direction; direction acts on this edge.
    assign at_term = (up == DIR_UP) ? (count_q == MAX_VAL) : (count_q == ZERO_VAL);
    assign load_ok = (din <= MAX_VAL);

    // Next-state: load beats enable; halted freezes counting until a valid load.
    always_comb begin
        count_d    = count_q;
        halted_d   = halted_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                count_d  = din;
                halted_d = 1'b0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en && !halted_q) begin
            if (at_term) begin
                wrap_d = 1'b1;
                if (HALT_EN) begin
                    halted_d = 1'b1;
                end else begin
                    count_d = (up == DIR_UP) ? ZERO_VAL : MAX_VAL;
                end
            end else begin
                count_d = (up == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    // State register with synchronous clear overriding everything else.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q    <= '0;
            halted_q   <= 1'b0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            halted_q   <= halted_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
    assign halted   = halted_q;
    // Cascade enable: true only when this stage will roll over on this edge.
    assign tc       = en & ~halted_q & at_term;

endmodule

// File: tb/tb_mod_n_counter.sv
// Randomised and directed checks of mod_n_counter against an arithmetic
// reference model, plus a two-stage cascade.
module tb_mod_n_counter;

    logic clk;
    logic clr, en, up, load;
    logic [3:0] din;

    logic [2:0][3:0] cnt_o;
    logic [2:0]      tc_o, wrap_o, err_o, halt_o;

    // Cascade pair
    logic       cc_clr, cc_en;
    logic [3:0] lo_cnt;
    logic [2:0] hi_cnt;
    logic       lo_tc, lo_wrap, lo_err, lo_halt;
    logic       hi_tc, hi_wrap, hi_err, hi_halt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int count;
        bit halted;
        bit wrap;
        bit err;
    } mstate_t;

    mstate_t m[3];
    int      mods[3] = '{12, 12, 2};
    bit      os[3]   = '{1'b0, 1'b1, 1'b0};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    mod_n_counter #(.WIDTH(4), .MODULUS(12), .ONE_SHOT(0)) u_free (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
        .count(cnt_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0]), .load_err(err_o[0]), .halted(halt_o[0]));

    mod_n_counter #(.WIDTH(4), .MODULUS(12), .ONE_SHOT(1)) u_shot (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
        .count(cnt_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1]), .load_err(err_o[1]), .halted(halt_o[1]));

    mod_n_counter #(.WIDTH(4), .MODULUS(2), .ONE_SHOT(0)) u_mod2 (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .din(din),
        .count(cnt_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2]), .load_err(err_o[2]), .halted(halt_o[2]));

    mod_n_counter #(.WIDTH(4), .MODULUS(12), .ONE_SHOT(0)) u_casc_lo (
        .clk(clk), .clr(cc_clr), .en(cc_en), .up(1'b1), .load(1'b0), .din(4'd0),
        .count(lo_cnt), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_err), .halted(lo_halt));

    mod_n_counter #(.WIDTH(3), .MODULUS(5), .ONE_SHOT(0)) u_casc_hi (
        .clk(clk), .clr(cc_clr), .en(lo_tc), .up(1'b1), .load(1'b0), .din(3'd0),
        .count(hi_cnt), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_err), .halted(hi_halt));

    // ---------------- checker ----------------
    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_tc(int i, bit en_i, bit up_i);
        if (!en_i || m[i].halted) return 1'b0;
        return up_i ? (m[i].count == mods[i] - 1) : (m[i].count == 0);
    endfunction

    function automatic void model_step(int i, bit clr_i, bit en_i, bit up_i, bit load_i, int din_i);
        mstate_t s;
        int      nxt;
        s      = m[i];
        s.wrap = 1'b0;
        s.err  = 1'b0;
        if (clr_i) begin
            s.count  = 0;
            s.halted = 1'b0;
        end else if (load_i) begin
            if (din_i < mods[i]) begin
                s.count  = din_i;
                s.halted = 1'b0;
            end else begin
                s.err = 1'b1;
            end
        end else if (en_i && !s.halted) begin
            nxt = s.count + (up_i ? 1 : -1);
            if (nxt < 0 || nxt >= mods[i]) begin
                s.wrap = 1'b1;
                if (os[i]) s.halted = 1'b1;
                else       s.count  = (nxt + mods[i]) % mods[i];
            end else begin
                s.count = nxt;
            end
        end
        m[i] = s;
    endfunction

    // ---------------- driver ----------------
    // One clock: drive at negedge, check tc before the edge, check registers after.
    task automatic step(input bit c, input bit e, input bit u, input bit l, input int d);
        @(negedge clk);
        clr  = c;
        en   = e;
        up   = u;
        load = l;
        din  = 4'(d);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("tc%0d", i), tc_o[i], model_tc(i, e, u));
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, c, e, u, l, d);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("count%0d", i),  cnt_o[i],  m[i].count);
            check($sformatf("wrap%0d", i),   wrap_o[i], m[i].wrap);
            check($sformatf("lderr%0d", i),  err_o[i],  m[i].err);
            check($sformatf("halted%0d", i), halt_o[i], m[i].halted);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
        cc_clr = 1'b0; cc_en = 1'b0;

        // Reset
        step(1, 0, 1, 0, 0);
        check("reset_count", cnt_o[0], 0);
        check("reset_halted", halt_o[1], 0);

        // Up count through a full period
        for (int k = 0; k < 13; k++) begin
            step(0, 1, 1, 0, 0);
            check("up_seq", cnt_o[0], (k + 1) % 12);
            check("up_wrap", wrap_o[0], (k == 11) ? 1 : 0);
        end

        // Down count from a load of 2
        step(0, 0, 1, 1, 2);
        check("dn_load", cnt_o[0], 2);
        step(0, 1, 0, 0, 0);  check("dn_1", cnt_o[0], 1);
        step(0, 1, 0, 0, 0);  check("dn_0", cnt_o[0], 0);
        step(0, 1, 0, 0, 0);  check("dn_11", cnt_o[0], 11);
        check("dn_wrap", wrap_o[0], 1);
        step(0, 0, 0, 0, 0);  check("dn_wrap_clear", wrap_o[0], 0);

        // Rejected then accepted load
        step(0, 0, 1, 1, 5);
        step(0, 1, 1, 1, 13);
        check("bad_load_hold", cnt_o[0], 5);
        check("bad_load_err", err_o[0], 1);
        step(0, 0, 1, 1, 7);
        check("good_load", cnt_o[0], 7);
        check("good_load_err", err_o[0], 0);

        // One-shot halt
        step(0, 0, 1, 1, 9);
        step(0, 1, 1, 0, 0);  check("os_10", cnt_o[1], 10);
        step(0, 1, 1, 0, 0);  check("os_11", cnt_o[1], 11);
        step(0, 1, 1, 0, 0);
        check("os_hold", cnt_o[1], 11);
        check("os_halted", halt_o[1], 1);
        check("os_wrap", wrap_o[1], 1);
        step(0, 1, 0, 0, 0);
        check("os_still", cnt_o[1], 11);
        check("os_wrap_once", wrap_o[1], 0);
        step(0, 0, 1, 1, 3);
        check("os_reload", cnt_o[1], 3);
        check("os_unhalt", halt_o[1], 0);

        // Priority: clr over load over en
        step(0, 0, 1, 1, 6);
        step(1, 1, 1, 1, 9);
        check("prio_clr", cnt_o[0], 0);
        step(0, 1, 1, 1, 4);
        check("prio_load", cnt_o[0], 4);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(39, 0) == 0),
                 ($urandom_range(3, 0) != 0),
                 1'($urandom_range(1, 0)),
                 ($urandom_range(5, 0) == 0),
                 int'($urandom_range(15, 0)));
        end

        // Cascade: 12 x 5 chain, second stage ticks once per 12 clocks
        @(negedge clk);
        en = 1'b0; load = 1'b0; clr = 1'b0;
        cc_clr = 1'b1; cc_en = 1'b0;
        @(posedge clk); #1;
        check("casc_rst_lo", lo_cnt, 0);
        check("casc_rst_hi", hi_cnt, 0);
        @(negedge clk);
        cc_clr = 1'b0; cc_en = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            check("casc_lo", lo_cnt, n % 12);
            check("casc_hi", hi_cnt, (n / 12) % 5);
        end
        check("casc_end_lo", lo_cnt, 0);
        check("casc_end_hi", hi_cnt, 0);
        @(negedge clk);
        cc_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
